// File: rtl/mem_if.sv
// Bus bundle for the LIFO stack: chip select, push/pop select, write data
// and the registered pop data. The master drives operations, the stack is the slave.
interface mem_if #(
    parameter int WIDTH = 8
);
    logic             cs;
    logic             p_p;
    logic [WIDTH-1:0] datain;
    logic [WIDTH-1:0] dataout;

    modport master (
        output cs,
        output p_p,
        output datain,
        input  dataout
    );

    modport slave (
        input  cs,
        input  p_p,
        input  datain,
        output dataout
    );
endinterface

// File: rtl/mem.sv
// LIFO stack of DEPTH words of WIDTH bits. The stack pointer counts valid
// entries (0..DEPTH). A pop registers the top word onto dataout on the same
// edge. Pushes when full and pops when empty are silently dropped.
module mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic  clk,
    input  logic  reset,
    mem_if.slave  bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] SP_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP
    } op_e;

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [AW:0]      sp_q, sp_d;
    logic [WIDTH-1:0] dataout_q, dataout_d;
    logic             empty, full;
    op_e              op;
    logic [AW-1:0]    wr_addr, rd_addr;

    // Decode the operation for this edge and compute next pointer / output.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        empty     = (sp_q == '0);
        full      = (sp_q == SP_FULL);
        op        = OP_NONE;
        sp_d      = sp_q;
        dataout_d = dataout_q;
        // Below DEPTH the low bits of sp address the next free slot; at
        // sp == DEPTH the low bits wrap to 0 so subtracting one gives DEPTH-1.
        wr_addr   = sp_q[AW-1:0];
        rd_addr   = sp_q[AW-1:0] - AW'(1);

        if (bus.cs) begin
            if (bus.p_p && !full) begin
                op = OP_PUSH;
            end else if (!bus.p_p && !empty) begin
                op = OP_POP;
            end
        end

        case (op)
            OP_PUSH: sp_d = sp_q + SP_ONE;
            OP_POP: begin
                sp_d      = sp_q - SP_ONE;
                dataout_d = stack_q[rd_addr];
            end
            default: ;
        endcase
    end

    // Pointer and output register with asynchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp_q      <= '0;
            dataout_q <= '0;
        end else begin
            sp_q      <= sp_d;
            dataout_q <= dataout_d;
        end
    end

    // Stack storage write port; writes are blocked while reset is asserted.
    // NOTE: the storage array is deliberately not reset -- with sp at 0 its
    // contents are unreachable, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (reset && op == OP_PUSH) begin
            stack_q[wr_addr] <= bus.datain;
        end
    end

    assign bus.dataout = dataout_q;

endmodule

// File: tb/tb_mem.sv
// Directed scoreboard bench for the LIFO stack. The stimulus process issues
// one operation per cycle and queues the dataout / stack-pointer values it
// expects after that edge; a monitor pops and compares after each edge.
module tb_mem;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    typedef struct {
        logic [WIDTH-1:0] dout;
        int               sp;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;
    exp_t exp_q[$];

    mem_if #(.WIDTH(WIDTH)) bus ();

    mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one operation for the coming rising edge and queue its outcome.
    task automatic op(input logic rst, input logic cs, input logic pp,
                      input logic [WIDTH-1:0] din,
                      input logic [WIDTH-1:0] exp_dout, input int exp_sp);
        @(negedge clk);
        reset      = rst;
        bus.cs     = cs;
        bus.p_p    = pp;
        bus.datain = din;
        exp_q.push_back('{dout: exp_dout, sp: exp_sp});
    endtask

    // Monitor: compare the DUT against the oldest expectation after each edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("dataout", 32'(bus.dataout), 32'(e.dout));
            check("sp", 32'(dut.sp_q), 32'(e.sp));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        reset      = 1'b0;
        bus.cs     = 1'b0;
        bus.p_p    = 1'b1;
        bus.datain = '0;

        // Reset held with an enabled push: nothing may happen.
        repeat (3) op(1'b0, 1'b1, 1'b1, 8'hAA, 8'h00, 0);

        // Basic LIFO.
        op(1'b1, 1'b1, 1'b1, 8'h0F, 8'h00, 1);
        op(1'b1, 1'b1, 1'b1, 8'h0B, 8'h00, 2);
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h0B, 1);
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h0F, 0);

        // Ordering over four entries.
        op(1'b1, 1'b1, 1'b1, 8'h4B, 8'h0F, 1);
        op(1'b1, 1'b1, 1'b1, 8'h2B, 8'h0F, 2);
        op(1'b1, 1'b1, 1'b1, 8'h8B, 8'h0F, 3);
        op(1'b1, 1'b1, 1'b1, 8'h0B, 8'h0F, 4);
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h0B, 3);
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h8B, 2);
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h2B, 1);
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h4B, 0);

        // Underflow: ignored pop, then normal push/pop.
        op(1'b1, 1'b1, 1'b0, 8'hEE, 8'h4B, 0);
        op(1'b1, 1'b1, 1'b1, 8'h11, 8'h4B, 1);
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h11, 0);

        // Alternating push/pop at full rate.
        op(1'b1, 1'b1, 1'b1, 8'h5A, 8'h11, 1);
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h5A, 0);
        op(1'b1, 1'b1, 1'b1, 8'hA5, 8'h5A, 1);
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'hA5, 0);

        // Overflow: 17 pushes, the last one dropped; then drain 16.
        for (int i = 1; i <= DEPTH + 1; i++)
            op(1'b1, 1'b1, 1'b1, 8'(i), 8'hA5, (i > DEPTH) ? DEPTH : i);
        for (int k = 0; k < DEPTH; k++)
            op(1'b1, 1'b1, 1'b0, 8'h00, 8'(DEPTH - k), DEPTH - 1 - k);

        // Chip select low: toggling p_p/datain must change nothing.
        op(1'b1, 1'b1, 1'b1, 8'h3C, 8'h01, 1);
        op(1'b1, 1'b1, 1'b1, 8'h3D, 8'h01, 2);
        op(1'b1, 1'b0, 1'b0, 8'hFF, 8'h01, 2);
        op(1'b1, 1'b0, 1'b1, 8'h77, 8'h01, 2);
        op(1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 2);
        op(1'b1, 1'b0, 1'b1, 8'hC3, 8'h01, 2);
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h3D, 1);
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h3C, 0);

        // Mid-operation reset: asynchronous clear, pending pop aborted.
        op(1'b1, 1'b1, 1'b1, 8'h99, 8'h3C, 1);
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h99, 0);
        op(1'b1, 1'b1, 1'b1, 8'h66, 8'h99, 1);
        @(negedge clk);
        bus.cs  = 1'b1;
        bus.p_p = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("async_reset_dataout", 32'(bus.dataout), 32'h0);
        check("async_reset_sp", 32'(dut.sp_q), 32'h0);
        exp_q.push_back('{dout: 8'h00, sp: 0});
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 0);
        op(1'b1, 1'b1, 1'b1, 8'h42, 8'h00, 1);
        op(1'b1, 1'b1, 1'b0, 8'h00, 8'h42, 0);

        @(negedge clk);
        bus.cs = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #5;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/mem.md
MEM -- requirements
Module: mem

Interface
REQ-001 Parameter: WIDTH, 8, data word width in bits.
REQ-002 Parameter: DEPTH, 16, number of stack entries (power of two, >= 2).
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port: cs  input  1  chip select; 1 enables a push or pop on the current edge.
REQ-006 Port: p_p  input  1  operation select; 1 = push, 0 = pop.
REQ-007 Port: datain  input  WIDTH  word to push.
REQ-008 Port: dataout  output  WIDTH  registered last popped word.

Function
REQ-009 The block SHALL implement a LIFO stack of DEPTH entries of WIDTH bits, addressed by an internal stack pointer sp of clog2(DEPTH)+1 bits (range 0..DEPTH) counting valid entries.
REQ-010 Internal status: empty = (sp == 0), full = (sp == DEPTH); neither is a port.
REQ-011 Push: on a rising edge with cs=1, p_p=1 and not full, stack[sp] <= datain and sp <= sp+1; dataout holds its value.
REQ-012 Pop: on a rising edge with cs=1, p_p=0 and not empty, dataout <= stack[sp-1] and sp <= sp-1; the popped entry need not be cleared.
REQ-013 Pop latency: the popped word SHALL appear on dataout immediately after the same rising edge (one register stage, no extra cycle).
REQ-014 Push when full SHALL be ignored: sp, stack contents and dataout unchanged, no wrap-around.
REQ-015 Pop when empty SHALL be ignored: sp unchanged, dataout holds its previous value, no underflow wrap.
REQ-016 With cs=0, sp, stack contents and dataout SHALL hold, regardless of p_p and datain.
REQ-017 Only one operation occurs per edge; p_p alone selects it, so push and pop cannot occur together.
REQ-018 Alternating push/pop on consecutive edges SHALL be supported at full rate with no bubble cycles.
REQ-019 If p_p is unknown (X) while cs=1, sp and dataout behaviour is unspecified; the bench drives p_p to a known value before the first enabled edge.

Reset
REQ-020 While reset=0, sp SHALL be 0 and dataout SHALL be all zeros, asynchronously and independent of clk.
REQ-021 Stack storage SHALL NOT be reset; contents are don't-care because sp=0 makes them unreachable.
REQ-022 Reset asserted mid-operation SHALL abort any pending push or pop; the first enabled edge after reset releases starts from an empty stack.
REQ-023 Reset release SHALL take effect at the next rising edge; no operation is performed while reset=0.

Verification
REQ-024 Reset: hold reset=0 with toggling clk, cs=1, p_p=1 -> dataout=8'h00, sp stays 0, no push performed.
REQ-025 Basic LIFO: push 8'h0F then 8'h0B, then pop twice -> dataout=8'h0B after the first pop edge and 8'h0F after the second.
REQ-026 Ordering: push 8'h4B, 8'h2B, 8'h8B, 8'h0B, then pop four times -> dataout sequence 8'h0B, 8'h8B, 8'h2B, 8'h4B, one word per edge.
REQ-027 Underflow: a fifth pop after REQ-026 -> dataout stays 8'h4B and sp stays 0; a following push of 8'h11 then a pop -> dataout=8'h11.
REQ-028 Overflow: push DEPTH+1 distinct words (8'h01..8'h11 for DEPTH=16), then pop DEPTH times -> first pop yields 8'h10 (8'h11 was dropped) and the last pop yields 8'h01.
REQ-029 Chip select: with cs=0, toggle p_p and datain for several edges -> dataout and stack contents unchanged; with cs=1, a pop returns the word pushed before cs was deasserted.
